// File: rtl/score_bcd_display.sv
// Score display stage: iterative 16-bit binary-to-BCD conversion (double dabble)
// feeding a time-multiplexed five-digit seven-segment driver.
module score_bcd_display #(
  parameter int unsigned REFRESH_DIV = 1024,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] score,
  input  logic        score_valid,
  output logic        busy,
  output logic        bcd_valid,
  output logic [19:0] bcd_out,
  output logic [6:0]  seg,
  output logic [4:0]  dig_sel
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [15:0]   shift_q, shift_d;
  logic [19:0]   acc_q, acc_d;
  logic [4:0]    step_q, step_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [19:0]   bcd_q, bcd_d;
  logic          valid_q, valid_d;
  logic [18:0]   acc_adj;
  logic [19:0]   acc_step;
  logic          last_step;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          wrap;
  logic [3:0]    digit;
  logic          upper_zero;

  // Top digit only needs three result bits: it never exceeds 6 after the final shift.
  always_comb begin
    acc_adj = '0;
    for (int k = 0; k < 4; k++) begin
      acc_adj[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ? acc_q[4*k +: 4] + 4'd3 : acc_q[4*k +: 4];
    end
    acc_adj[18:16] = (acc_q[19:16] >= 4'd5) ? acc_q[18:16] + 3'd3 : acc_q[18:16];
  end

  assign acc_step  = {acc_adj, shift_q[15]};
  assign last_step = (step_q == 5'd15);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    step_d   = step_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    bcd_d    = bcd_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (score_valid) begin
          state_d = CONVERT;
          shift_d = score;
          acc_d   = '0;
          step_d  = '0;
        end
      end
      CONVERT: begin
        shift_d = {shift_q[14:0], 1'b0};
        acc_d   = acc_step;
        step_d  = step_q + 5'd1;
        if (last_step) begin
          bcd_d   = acc_step;
          valid_d = 1'b1;
          step_d  = '0;
          acc_d   = '0;
          // A strobe on the completion edge beats the older pending score.
          if (score_valid) begin
            shift_d  = score;
            pend_v_d = 1'b0;
          end else if (pend_v_q) begin
            shift_d  = pend_q;
            pend_v_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (score_valid) begin
          pend_d   = score;
          pend_v_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      bcd_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
    end
  end

  assign busy      = (state_q == CONVERT);
  assign bcd_valid = valid_q;
  assign bcd_out   = bcd_q;

  assign wrap = (cnt_q == CW'(REFRESH_DIV - 1));

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (wrap) idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    digit      = bcd_q[3:0];
    upper_zero = 1'b0;
    case (idx_q)
      3'd1: begin digit = bcd_q[7:4];   upper_zero = (bcd_q[19:4]  == 16'd0); end
      3'd2: begin digit = bcd_q[11:8];  upper_zero = (bcd_q[19:8]  == 12'd0); end
      3'd3: begin digit = bcd_q[15:12]; upper_zero = (bcd_q[19:12] == 8'd0);  end
      3'd4: begin digit = bcd_q[19:16]; upper_zero = (bcd_q[19:16] == 4'd0);  end
      default: begin digit = bcd_q[3:0]; upper_zero = 1'b0; end
    endcase
  end

  always_comb begin
    seg = 7'h00;
    case (digit)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    if (BLANK_LZ && upper_zero) seg = 7'h00;
  end

  assign dig_sel = 5'(1) << idx_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Bench for score_bcd_display: arithmetic reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized strobes.
module tb_score_bcd_display;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] score = '0;
  logic        score_valid = 1'b0;
  logic        busy, bcd_valid;
  logic [19:0] bcd_out;
  logic [6:0]  seg;
  logic [4:0]  dig_sel;
  logic        busy_n, bcd_valid_n;
  logic [19:0] bcd_out_n;
  logic [6:0]  seg_n;
  logic [4:0]  dig_sel_n;

  score_bcd_display #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
    .busy(busy), .bcd_valid(bcd_valid), .bcd_out(bcd_out), .seg(seg), .dig_sel(dig_sel)
  );

  score_bcd_display #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
    .busy(busy_n), .bcd_valid(bcd_valid_n), .bcd_out(bcd_out_n), .seg(seg_n), .dig_sel(dig_sel_n)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r = '0;
    int p = 1;
    for (int k = 0; k < 5; k++) begin
      r |= 20'((v / p) % 10) << (4 * k);
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int idx, input bit blank);
    int p = 1;
    for (int i = 0; i < idx; i++) p *= 10;
    if (blank && idx > 0 && v < p) return 7'h00;
    return seg_tab[(v / p) % 10];
  endfunction

  // Reference model: transaction-level view of the converter and display.
  bit   m_busy, m_pend_v, m_valid;
  int   m_cnt, m_cur, m_pend, m_val, m_ticks;
  logic [19:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_pend_v = 0; m_valid = 0;
      m_cnt = 0; m_cur = 0; m_pend = 0; m_val = 0; m_ticks = 0;
      exp_q.delete();
    end else begin
      m_valid = 0;
      m_ticks++;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == 16) begin
          m_val = m_cur;
          m_valid = 1;
          exp_q.push_back(to_bcd(m_cur));
          if (score_valid) begin m_cur = score; m_cnt = 0; m_pend_v = 0; end
          else if (m_pend_v) begin m_cur = m_pend; m_cnt = 0; m_pend_v = 0; end
          else m_busy = 0;
        end else if (score_valid) begin
          m_pend = score; m_pend_v = 1;
        end
      end else if (score_valid) begin
        m_cur = score; m_cnt = 0; m_busy = 1;
      end
    end
  end

  logic [19:0] got_q[$];
  int          ts_q[$];
  int          cyc = 0;
  int          run_len = 0;
  int          last_run = 0;

  always @(negedge clk) begin
    int idx;
    idx = (m_ticks / RD) % 5;
    cyc++;
    check("busy", busy, m_busy);
    check("bcd_valid", bcd_valid, m_valid);
    check("bcd_out", bcd_out, to_bcd(m_val));
    check("dig_sel", dig_sel, 32'd1 << idx);
    check("seg", seg, exp_seg(m_val, idx, 1'b1));
    check("seg_nb", seg_n, exp_seg(m_val, idx, 1'b0));
    check("dig_sel_nb", dig_sel_n, 32'd1 << idx);
    check("bcd_out_nb", bcd_out_n, to_bcd(m_val));
    check("busy_nb", {busy_n, bcd_valid_n}, {m_busy, m_valid});
    if (bcd_valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else check("result_order", bcd_out, exp_q.pop_front());
      got_q.push_back(bcd_out);
      ts_q.push_back(cyc);
    end
    if (busy) run_len++;
    else if (run_len != 0) begin last_run = run_len; run_len = 0; end
  end

  task automatic drive(input bit v, input logic [15:0] s);
    score_valid = v;
    score = s;
    @(posedge clk); #2;
  endtask

  task automatic strobe(input logic [15:0] s);
    drive(1'b1, s);
    drive(1'b0, 16'd0);
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 200 && got_q.size() < n; i++) begin
      @(negedge clk); #1;
    end
    check("results_count", got_q.size(), n);
  endtask

  task automatic wait_dig(input int idx);
    for (int i = 0; i < 40 && dig_sel !== (5'(1) << idx); i++) begin
      @(negedge clk); #1;
    end
    check("dig_wait", dig_sel, 32'd1 << idx);
  endtask

  logic [6:0] seq_65535 [5] = '{7'h6D, 7'h4F, 7'h6D, 7'h6D, 7'h7D};
  logic [15:0] picks [6] = '{16'd0, 16'd9, 16'd10, 16'd99, 16'd100, 16'd65535};

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_valid", bcd_valid, 0);
    check("rst_bcd", bcd_out, 20'h00000);
    check("rst_dig", dig_sel, 5'b00001);
    check("rst_seg", seg, 7'h3F);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Zero: units shows 0, higher digits blanked.
    got_q.delete();
    strobe(16'd0);
    wait_results(1);
    check("zero_val", got_q[0], 20'h00000);
    repeat (2) @(negedge clk); #1;
    check("zero_busy_len", last_run, 16);
    wait_dig(0);
    check("zero_seg0", seg, 7'h3F);
    wait_dig(2);
    check("zero_seg2", seg, 7'h00);
    check("zero_seg2_nb", seg_n, 7'h3F);

    // Full scale and the digit scan it produces.
    got_q.delete();
    strobe(16'd65535);
    wait_results(1);
    check("max_val", got_q[0], 20'h65535);
    wait_dig(4);
    wait_dig(0);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < RD; j++) begin
        check("max_scan_seg", seg, seq_65535[k]);
        check("max_scan_dig", dig_sel, 32'd1 << k);
        @(negedge clk); #1;
      end
    end

    got_q.delete();
    strobe(16'd1234);
    wait_results(1);
    check("v1234", got_q[0], 20'h01234);
    wait_dig(4);
    check("v1234_d4_blank", seg, 7'h00);
    check("v1234_d4_nb", seg_n, 7'h3F);
    wait_dig(3);
    check("v1234_d3", seg, 7'h06);

    // Newest pending strobe wins, back-to-back conversions.
    got_q.delete(); ts_q.delete();
    strobe(16'd100);
    drive(1'b0, 16'd0);
    drive(1'b0, 16'd0);
    strobe(16'd200);
    strobe(16'd300);
    wait_results(2);
    repeat (3) @(negedge clk); #1;
    check("pend_first", got_q[0], 20'h00100);
    check("pend_second", got_q[1], 20'h00300);
    check("pend_gap", ts_q[1] - ts_q[0], 16);
    check("pend_busy_len", last_run, 32);

    // Reset mid-conversion discards the result.
    got_q.delete();
    strobe(16'd500);
    repeat (6) drive(1'b0, 16'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_dig", dig_sel, 5'b00001);
    check("midrst_busy", busy, 0);
    check("midrst_bcd", bcd_out, 20'h00000);
    repeat (2) @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (40) @(negedge clk); #1;
    check("midrst_no_valid", got_q.size(), 0);
    check("midrst_bcd_hold", bcd_out, 20'h00000);

    // Strobe on the completion edge overrides the pending score.
    got_q.delete();
    drive(1'b1, 16'd7);
    drive(1'b1, 16'd99);
    repeat (14) drive(1'b0, 16'd0);
    drive(1'b1, 16'd42);
    drive(1'b0, 16'd0);
    wait_results(2);
    repeat (40) @(negedge clk); #1;
    check("coinc_first", got_q[0], 20'h00007);
    check("coinc_second", got_q[1], 20'h00042);
    check("coinc_count", got_q.size(), 2);

    // Randomized strobes with one reset in the middle.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] s;
      s = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 5)] : 16'($urandom_range(0, 65535));
      if (i == 300) begin
        rst_n = 1'b0;
        drive(1'b0, 16'd0);
        rst_n = 1'b1;
      end else begin
        drive($urandom_range(0, 7) == 0, s);
      end
    end
    repeat (40) drive(1'b0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
